pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. It generalises the 4-bit ripple-carry adder to WIDTH bits and breaks the carry chain into CHUNK-bit slices, one pipeline stage per slice, so that the critical path is CHUNK full-adder delays. It sits in the datapath wherever a wide add or subtract must meet the clock, and it accepts one operation per cycle when the output side is not stalled.

---
 rtl/pipelined_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_addsub.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, carry chain split into CHUNK-bit slices.
// Latency: STAGES = WIDTH/CHUNK cycles from accept to OUT_VALID; one op per cycle.
// Backpressure: whole pipe advances only when ~OUT_VALID | OUT_READY; IN_READY is that enable.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   A, B, CI, SUB         operands; SUB=1 computes A - B - CI (CI acts as borrow-in)
//   IN_VALID / IN_READY   input handshake
//   S, CO, OVF            result, raw carry out of the MSB, signed overflow
//   OUT_VALID / OUT_READY output handshake
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_q;

  // Subtraction as A + ~B + ~CI: inverting the borrow-in turns it into the +1 of the negation.
  assign b_eff    = SUB ? ~B : B;
  assign c0       = SUB ? ~CI : CI;
  assign en       = ~OUT_VALID | OUT_READY;
  assign IN_READY = en;

  // Stage k register holds: result slices 0..k (de-skew), carry out of slice k,
  // and the operand slices above k (skew) still waiting for their turn.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int SW = (k + 1) * CHUNK;

    logic             vld;
    logic             cy;
    logic [SW-1:0]    sum;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             c_in;
    logic             v_in;
    logic [CHUNK:0]   add;
    logic [SW-1:0]    sum_nxt;

    assign add = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : src
      assign a_sl    = A[CHUNK-1:0];
      assign b_sl    = b_eff[CHUNK-1:0];
      assign c_in    = c0;
      assign v_in    = IN_VALID;
      assign sum_nxt = add[CHUNK-1:0];
    end else begin : src
      assign a_sl    = stg[k-1].skew.a_sk[CHUNK-1:0];
      assign b_sl    = stg[k-1].skew.b_sk[CHUNK-1:0];
      assign c_in    = stg[k-1].cy;
      assign v_in    = stg[k-1].vld;
      assign sum_nxt = {add[CHUNK-1:0], stg[k-1].sum};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        cy  <= 1'b0;
        sum <= '0;
      end else if (en) begin
        vld <= v_in;
        cy  <= add[CHUNK];
        sum <= sum_nxt;
      end
    end

    if (k < STAGES - 1) begin : skew
      localparam int KW = WIDTH - SW;

      logic [KW-1:0] a_sk;
      logic [KW-1:0] b_sk;
      logic [KW-1:0] a_nx;
      logic [KW-1:0] b_nx;

      if (k == 0) begin : nx
        assign a_nx = A[WIDTH-1:CHUNK];
        assign b_nx = b_eff[WIDTH-1:CHUNK];
      end else begin : nx
        assign a_nx = stg[k-1].skew.a_sk[KW+CHUNK-1:CHUNK];
        assign b_nx = stg[k-1].skew.b_sk[KW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk <= '0;
          b_sk <= '0;
        end else if (en) begin
          a_sk <= a_nx;
          b_sk <= b_nx;
        end
      end
    end else begin : tail
      // Carry into the MSB is recovered from the MSB sum bit (a ^ b ^ cin), which
      // also works when a slice is a single bit wide.
      logic ovf_nxt;
      assign ovf_nxt = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ add[CHUNK-1] ^ add[CHUNK];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_nxt;
        end
      end
    end
  end

  assign S         = stg[STAGES-1].sum;
  assign CO        = stg[STAGES-1].cy;
  assign OVF       = ovf_q;
  assign OUT_VALID = stg[STAGES-1].vld;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub at WIDTH=16, CHUNK=4 (latency 4).
module tb_pipelined_addsub;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s;
  logic        co;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int n_chk;
  int n_err;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .CI       (ci),
    .SUB      (sub),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .S        (s),
    .CO       (co),
    .OVF      (ovf),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {co, ovf, s}, derived from 17-bit arithmetic and operand signs.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mci, input logic msub);
    logic [16:0] full;
    logic [15:0] ms;
    logic        mco;
    logic        movf;
    if (!msub) begin
      full = {1'b0, ma} + {1'b0, mb} + {16'b0, mci};
      mco  = full[16];
    end else begin
      full = {1'b0, ma} - {1'b0, mb} - {16'b0, mci};
      mco  = ~full[16];
    end
    ms   = full[15:0];
    movf = msub ? ((ma[15] != mb[15]) && (ms[15] != ma[15]))
                : ((ma[15] == mb[15]) && (ms[15] != ma[15]));
    return {mco, movf, ms};
  endfunction

  // One operation through an empty pipe with OUT_READY held high.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tci, input logic tsub,
                         input logic [15:0] es, input logic eco, input logic eovf);
    a = ta; b = tb_; ci = tci; sub = tsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_s"},   32'(s),   32'(es));
    chk({tag, "_co"},  32'(co),  32'(eco));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    step();
  endtask

  logic [15:0] fa [6] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h00FF, 16'h7000};
  logic [15:0] fb [6] = '{16'h0002, 16'h0001, 16'h8000, 16'h0234, 16'h0F01, 16'h1000};
  logic        fc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        fs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] q [$];
    logic [17:0] exp_v;
    logic [17:0] held_v;
    logic        held;
    logic [15:0] st_a;
    logic [15:0] st_b;
    logic        st_c;
    logic        st_s;
    int          n_acc;
    int          n_out;
    int          cyc;
    int          idx;

    n_chk = 0;
    n_err = 0;
    rst = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s",   32'(s),   32'd0);
    chk("rst_co",  32'(co),  32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    // Directed vectors
    run_one("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_one("carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_bin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Random stream with toggling OUT_READY
    n_acc = 0; n_out = 0; cyc = 0; held = 1'b0; held_v = '0;
    st_a = 16'($urandom); st_b = 16'($urandom);
    st_c = 1'($urandom_range(0, 1)); st_s = 1'($urandom_range(0, 1));
    while (n_out < 16 && cyc < 400) begin
      in_valid = (n_acc < 16);
      a = st_a; b = st_b; ci = st_c; sub = st_s;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        chk("hold_vld", 32'(out_valid), 32'd1);
        chk("hold_out", 32'({co, ovf, s}), 32'(held_v));
      end
      held   = out_valid & ~out_ready;
      held_v = {co, ovf, s};
      if (in_valid && in_ready) begin
        q.push_back(model(st_a, st_b, st_c, st_s));
        n_acc++;
        st_a = 16'($urandom); st_b = 16'($urandom);
        st_c = 1'($urandom_range(0, 1)); st_s = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) begin
        chk("stream_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (q.size() > 0) begin
          exp_v = q.pop_front();
          chk("stream_s",   32'(s),   32'(exp_v[15:0]));
          chk("stream_co",  32'(co),  32'(exp_v[17]));
          chk("stream_ovf", 32'(ovf), 32'(exp_v[16]));
        end
        n_out++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_acc",   32'(n_acc), 32'd16);
    chk("stream_count", 32'(n_out), 32'd16);
    chk("stream_left",  32'(q.size()), 32'd0);
    repeat (5) step();
    chk("stream_no_extra", 32'(out_valid), 32'd0);

    // Fill then drain
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        a = fa[idx]; b = fb[idx]; ci = fc[idx]; sub = fs[idx];
      end
      #1;
      if (in_valid && in_ready) idx++;
      step();
    end
    #1;
    chk("fill_accepted", 32'(idx), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v = model(fa[i], fb[i], fc[i], fs[i]);
      chk("drain_vld", 32'(out_valid), 32'd1);
      chk("drain_out", 32'({co, ovf, s}), 32'(exp_v));
      step();
    end
    chk("drain_end", 32'(out_valid), 32'd0);

    // Reset with 3 operations in flight
    for (int i = 0; i < 3; i++) begin
      a = fa[i]; b = fb[i]; ci = fc[i]; sub = fs[i];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    chk("flush_vld", 32'(out_valid), 32'd0);
    chk("flush_s",   32'(s),   32'd0);
    chk("flush_co",  32'(co),  32'd0);
    chk("flush_ovf", 32'(ovf), 32'd0);
    run_one("post_rst", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
